pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// In-order pipeline hazard controller: operand bypass, load-use stall, flush, halt/drain, write-back.
// Optional build macro PIPE_CTRL_PERF_EN adds 32-bit stall/flush/retire counters.
module pipe_ctrl #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_is_load,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  input  logic              halt_req,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       retire_cnt
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] s_vld;
  logic [STAGES-1:0] s_wen;
  logic [STAGES-1:0] s_ld;
  logic [REG_AW-1:0] s_rd  [STAGES];
  logic [DATA_W-1:0] s_dat [STAGES];
  logic [DATA_W-1:0] s_fwd [STAGES];

  logic [REG_AW-1:0] rs      [2];
  logic [DATA_W-1:0] fdat    [2];
  logic [1:0]        hit;
  logic [1:0]        use_ld;

  logic halt_q;
  logic halted_q;
  logic halt_eff;
  logic stall;
  logic accept;
  logic any_vld;

  assign rs[0] = in_rs1;
  assign rs[1] = in_rs2;

  // Value a consumer would read from each stage this cycle.
  always_comb begin
    for (int k = 0; k < STAGES; k++) s_fwd[k] = s_dat[k];
    s_fwd[0] = ex_result;
    s_fwd[1] = s_ld[1] ? mem_rdata : s_dat[1];
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      hit[j]    = 1'b0;
      use_ld[j] = 1'b0;
      fdat[j]   = '0;
      for (int k = LAST; k >= 0; k--) begin
        if (s_vld[k] && s_wen[k] && (s_rd[k] != '0) && (s_rd[k] == rs[j])) begin
          hit[j]    = 1'b1;
          fdat[j]   = s_fwd[k];
          use_ld[j] = (k == 0) && s_ld[k];
        end
      end
    end
  end

  assign fwd_hit1  = hit[0];
  assign fwd_hit2  = hit[1];
  assign fwd_data1 = fdat[0];
  assign fwd_data2 = fdat[1];

  // A flush already discards the decode slot, so it suppresses the load-use stall.
  assign stall    = (|use_ld) & ~flush;
  assign halt_eff = halt_q | halt_req;
  assign in_ready = ~stall & ~halt_eff;
  assign accept   = in_valid & in_ready & ~flush;
  assign any_vld  = |s_vld;
  assign halted   = halted_q | (halt_eff & ~any_vld);

  assign wb_valid = s_vld[LAST] & s_wen[LAST] & (s_rd[LAST] != '0);
  assign wb_rd    = s_rd[LAST];
  assign wb_data  = s_dat[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld    <= '0;
      s_wen    <= '0;
      s_ld     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        s_rd[k]  <= '0;
        s_dat[k] <= '0;
      end
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      s_vld[0] <= accept;
      s_wen[0] <= accept & in_wen;
      s_ld[0]  <= accept & in_is_load;
      s_rd[0]  <= accept ? in_rd : '0;
      s_dat[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        s_vld[k] <= s_vld[k-1];
        s_wen[k] <= s_wen[k-1];
        s_ld[k]  <= s_ld[k-1];
        s_rd[k]  <= s_rd[k-1];
        s_dat[k] <= s_dat[k-1];
      end
      s_dat[1] <= ex_result;
      s_dat[2] <= s_ld[1] ? mem_rdata : s_dat[1];
      halt_q   <= halt_eff;
      halted_q <= halted;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else begin
      stall_q  <= stall_q + {31'd0, stall};
      flush_q  <= flush_q + {31'd0, flush};
      retire_q <= retire_q + {31'd0, wb_valid};
    end
  end

  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign retire_cnt = retire_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized scoreboard bench for pipe_ctrl: an age-based instruction model predicts every cycle's outputs.
module tb_pipe_ctrl;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int ST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_wen, in_is_load, in_ready, flush, halt_req;
  logic [AW-1:0] in_rd, in_rs1, in_rs2, wb_rd;
  logic [DW-1:0] ex_result, mem_rdata, fwd_data1, fwd_data2, wb_data;
  logic          fwd_hit1, fwd_hit2, wb_valid, halted;
  logic [31:0]   stall_cnt, flush_cnt, retire_cnt;

  pipe_ctrl #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rd(in_rd), .in_wen(in_wen),
    .in_is_load(in_is_load), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ready(in_ready),
    .ex_result(ex_result), .mem_rdata(mem_rdata), .flush(flush), .halt_req(halt_req),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
  );

  // One accepted instruction; its stage at cycle c is c - issue - 1.
  typedef struct {
    int          issue;
    logic [AW-1:0] rd;
    bit          wen;
    bit          ld;
    logic [DW-1:0] exv;
    logic [DW-1:0] memv;
  } rec_t;

  typedef struct {
    bit          rdy, h1, h2, wbv, chk_wb, hlt;
    logic [DW-1:0] d1, d2, wdat;
    logic [AW-1:0] wrd;
    logic [31:0] sc, fc, rc;
  } exp_t;

  rec_t fl[$];
  exp_t sb[$];
  exp_t cur_e, mon_e;
  bit   cur_stall;
  int   cyc = 0;
  bit   halt_lat, halted_m, fresh;
  logic [31:0] m_st, m_fl, m_rt;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void fwd(input logic [AW-1:0] rs, input logic [DW-1:0] ex, input logic [DW-1:0] mem,
                              output bit hit, output logic [DW-1:0] val, output bit ld0);
    int best;
    best = ST;
    hit = 1'b0; val = '0; ld0 = 1'b0;
    foreach (fl[i]) begin
      int a;
      a = cyc - fl[i].issue - 1;
      if (fl[i].wen && fl[i].rd != 0 && fl[i].rd == rs && a < best) begin
        best = a;
        hit  = 1'b1;
        ld0  = (a == 0) && fl[i].ld;
        if (a == 0)       val = ex;
        else if (!fl[i].ld) val = fl[i].exv;
        else if (a == 1)  val = mem;
        else              val = fl[i].memv;
      end
    end
  endfunction

  task automatic drive(bit v, int rdv, bit w, bit l, int r1, int r2,
                       logic [DW-1:0] ex, logic [DW-1:0] mem, bit f, bit h, bit r);
    exp_t e;
    bit ld1, ld2;
    in_valid = v; in_rd = AW'(rdv); in_wen = w; in_is_load = l;
    in_rs1 = AW'(r1); in_rs2 = AW'(r2); ex_result = ex; mem_rdata = mem;
    flush = f; halt_req = h; rst = r;
    foreach (fl[i]) begin
      if (cyc - fl[i].issue - 1 == 0) fl[i].exv  = ex;
      if (cyc - fl[i].issue - 1 == 1) fl[i].memv = mem;
    end
    fwd(in_rs1, ex, mem, e.h1, e.d1, ld1);
    fwd(in_rs2, ex, mem, e.h2, e.d2, ld2);
    cur_stall = (ld1 || ld2) && !f;
    e.rdy = !cur_stall && !(halt_lat || h);
    e.hlt = halted_m || ((halt_lat || h) && fl.size() == 0);
    e.wbv = 1'b0; e.chk_wb = fresh; e.wrd = '0; e.wdat = '0;
    foreach (fl[i]) begin
      if (cyc - fl[i].issue - 1 == ST - 1) begin
        e.wbv    = fl[i].wen && fl[i].rd != 0;
        e.chk_wb = fresh || e.wbv;
        e.wrd    = fl[i].rd;
        e.wdat   = fl[i].ld ? fl[i].memv : fl[i].exv;
      end
    end
`ifdef PIPE_CTRL_PERF_EN
    e.sc = m_st; e.fc = m_fl; e.rc = m_rt;
`else
    e.sc = '0; e.fc = '0; e.rc = '0;
`endif
    cur_e = e;
    sb.push_back(e);
  endtask

  task automatic adv();
    rec_t n;
    @(posedge clk);
    if (rst) begin
      fl.delete();
      halt_lat = 1'b0; halted_m = 1'b0; fresh = 1'b1;
      m_st = '0; m_fl = '0; m_rt = '0;
    end else begin
      if (in_valid && cur_e.rdy && !flush) begin
        n.issue = cyc; n.rd = in_rd; n.wen = in_wen; n.ld = in_is_load; n.exv = '0; n.memv = '0;
        fl.push_back(n);
      end
      if (cur_stall) m_st++;
      if (flush) m_fl++;
      if (cur_e.wbv) m_rt++;
      halt_lat = halt_lat || halt_req;
      halted_m = cur_e.hlt;
      fresh = 1'b0;
      while (fl.size() != 0 && cyc - fl[0].issue - 1 >= ST - 1) void'(fl.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("in_ready", 64'(in_ready), 64'(mon_e.rdy));
      chk("fwd_hit1", 64'(fwd_hit1), 64'(mon_e.h1));
      chk("fwd_hit2", 64'(fwd_hit2), 64'(mon_e.h2));
      chk("fwd_data1", fwd_data1, mon_e.d1);
      chk("fwd_data2", fwd_data2, mon_e.d2);
      chk("wb_valid", 64'(wb_valid), 64'(mon_e.wbv));
      if (mon_e.chk_wb) begin
        chk("wb_rd", 64'(wb_rd), 64'(mon_e.wrd));
        chk("wb_data", wb_data, mon_e.wdat);
      end
      chk("halted", 64'(halted), 64'(mon_e.hlt));
      chk("stall_cnt", 64'(stall_cnt), 64'(mon_e.sc));
      chk("flush_cnt", 64'(flush_cnt), 64'(mon_e.fc));
      chk("retire_cnt", 64'(retire_cnt), 64'(mon_e.rc));
    end
  end

  initial begin
    int wbs;
    bit v, w, l, f, h, r;
    in_valid = 0; in_rd = '0; in_wen = 0; in_is_load = 0; in_rs1 = '0; in_rs2 = '0;
    ex_result = '0; mem_rdata = '0; flush = 0; halt_req = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    fresh = 1'b1; halt_lat = 0; halted_m = 0; m_st = '0; m_fl = '0; m_rt = '0;

    // Forward from EX: x1 = 5, then a reader of x1.
    drive(1, 1, 1, 0, 0, 0, 64'd1, '0, 0, 0, 0); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    adv();
    drive(1, 2, 1, 0, 1, 0, 64'd5, '0, 0, 0, 0); #1;
    chk("s_ex_hit", 64'(fwd_hit1), 64'd1);
    chk("s_ex_data", fwd_data1, 64'd5);
    adv();

    // Load-use: one stall cycle, then forward load data from MEM.
    drive(1, 3, 1, 1, 0, 0, 64'h100, '0, 0, 0, 0); adv();
    drive(1, 4, 1, 0, 3, 0, 64'h7, 64'h55, 0, 0, 0); #1;
    chk("s_lu_stall", 64'(in_ready), 64'd0);
    adv();
    drive(1, 4, 1, 0, 3, 0, 64'h7, 64'hAA, 0, 0, 0); #1;
    chk("s_lu_ready", 64'(in_ready), 64'd1);
    chk("s_lu_data", fwd_data1, 64'hAA);
    adv();

    // x0 writer: never forwarded, never written back.
    drive(1, 0, 1, 0, 0, 0, 64'h9, '0, 0, 0, 0); adv();
    drive(1, 5, 0, 0, 0, 0, 64'h9, '0, 0, 0, 0); #1;
    chk("s_x0_hit", 64'(fwd_hit1), 64'd0);
    adv();
    idle(); adv(); idle(); adv();
    idle(); #1;
    chk("s_x0_wb", 64'(wb_valid), 64'd0);
    adv();
    repeat (ST) begin idle(); adv(); end

    // Flush while a load-use hazard is pending.
    drive(1, 5, 1, 1, 0, 0, 64'h11, '0, 0, 0, 0); adv();
    drive(1, 9, 1, 0, 5, 0, 64'h22, 64'h33, 1, 0, 0); adv();
    idle(); adv(); idle(); adv();
    idle(); #1;
    chk("s_fl_wbv", 64'(wb_valid), 64'd1);
    chk("s_fl_wbrd", 64'(wb_rd), 64'd5);
    adv();
    idle(); #1;
    chk("s_fl_disc", 64'(wb_valid), 64'd0);
    adv();

    // Halt with three writers in flight.
    drive(1, 6, 1, 0, 0, 0, 64'h6, '0, 0, 0, 0); adv();
    drive(1, 7, 1, 0, 0, 0, 64'h7, '0, 0, 0, 0); adv();
    drive(1, 8, 1, 0, 0, 0, 64'h8, '0, 0, 0, 0); adv();
    wbs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 10, 1, 0, 0, 0, 64'h10, '0, 0, (i == 0), 0); #1;
      if (wb_valid) wbs++;
      adv();
    end
    chk("s_halt_wbs", 64'(wbs), 64'd3);
    drive(1, 11, 1, 0, 0, 0, '0, '0, 0, 0, 0); #1;
    chk("s_halt_halted", 64'(halted), 64'd1);
    chk("s_halt_rdy", 64'(in_ready), 64'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0, '0, '0, 0, 0, 1); adv();

    // Randomized traffic with occasional flush, halt and reset.
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 4) != 0);
      l = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 149) == 0);
      r = halted_m ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      drive(v, $urandom_range(0, 7), w, l, $urandom_range(0, 7), $urandom_range(0, 7),
            {$urandom, $urandom}, {$urandom, $urandom}, f, h, r);
      adv();
    end

    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
